// File: rtl/ctrl_pkg.sv
// Shared encodings for the R/I/J CPU sequencing controller: states, opcodes,
// funct codes, instruction classes and the datapath select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        IC_R_ALU,
        IC_LOAD,
        IC_STORE,
        IC_BR,
        IC_JMP,
        IC_JR,
        IC_JAL,
        IC_IMM,
        IC_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    localparam logic [1:0] NPC_BRANCH = 2'b00;
    localparam logic [1:0] NPC_JIMM   = 2'b01;
    localparam logic [1:0] NPC_JR     = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        iclass_t    iclass;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       br_ne;
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps opcode/funct to an instruction
// class plus the ALU operation and operand select used in EXEC.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // NOTE: every field gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        dec = '{iclass: IC_ILL, alu_op: ALU_ADD, alu_src: 1'b0, br_ne: 1'b0};
        case (opcode)
            OP_RTYPE: begin
                dec.iclass = IC_R_ALU;
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_JR:   dec.iclass = IC_JR;
                    default: dec.iclass = IC_ILL;
                endcase
            end
            OP_LW:   dec = '{iclass: IC_LOAD,  alu_op: ALU_ADD,   alu_src: 1'b1, br_ne: 1'b0};
            OP_SW:   dec = '{iclass: IC_STORE, alu_op: ALU_ADD,   alu_src: 1'b1, br_ne: 1'b0};
            OP_BEQ:  dec = '{iclass: IC_BR,    alu_op: ALU_SUB,   alu_src: 1'b0, br_ne: 1'b0};
            OP_BNE:  dec = '{iclass: IC_BR,    alu_op: ALU_SUB,   alu_src: 1'b0, br_ne: 1'b1};
            OP_ADDI: dec = '{iclass: IC_IMM,   alu_op: ALU_ADD,   alu_src: 1'b1, br_ne: 1'b0};
            OP_ORI:  dec = '{iclass: IC_IMM,   alu_op: ALU_OR,    alu_src: 1'b1, br_ne: 1'b0};
            OP_J:    dec = '{iclass: IC_JMP,   alu_op: ALU_PASSB, alu_src: 1'b0, br_ne: 1'b0};
            OP_JAL:  dec = '{iclass: IC_JAL,   alu_op: ALU_PASSB, alu_src: 1'b0, br_ne: 1'b0};
            default: dec.iclass = IC_ILL;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the R/I/J CPU.
// Define CTRL_PERF_CNT_EN to add the cyc_cnt/ret_cnt performance counters.
module cpu_seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       if_en,
    output logic       cond,
    output logic [1:0] npc_sel,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic       mem_re,
    output logic       mem_we,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       illegal,
    output logic       bus_err
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    state_t      cur_state, next_state;
    logic [5:0]  op_q, fn_q;
    logic [5:0]  dec_op, dec_fn;
    dec_t        dec;
    logic [31:0] wait_cnt;
    logic        timeout;

    logic       if_en_d, cond_d, reg_we_d, alu_src_d, mem_re_d, mem_we_d;
    logic       illegal_d, bus_err_d;
    logic [1:0] npc_sel_d, reg_dst_d, wb_sel_d;
    logic [2:0] alu_op_d;

    assign state = cur_state;

    // DECODE sees the live IR; every later state works from the captured copy.
    assign dec_op = (cur_state == ST_DECODE) ? opcode : op_q;
    assign dec_fn = (cur_state == ST_DECODE) ? funct  : fn_q;

    ctrl_decode u_decode (
        .opcode (dec_op),
        .funct  (dec_fn),
        .dec    (dec)
    );

    // NOTE: the IR capture needs no reset; it is always written in DECODE before anything reads it.
    always_ff @(posedge clk) begin
        if (cur_state == ST_DECODE) begin
            op_q <= opcode;
            fn_q <= funct;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && (cur_state == ST_MEM) && !mem_ready &&
                     (wait_cnt == 32'(MEM_TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_FETCH;
            wait_cnt  <= '0;
        end else begin
            cur_state <= next_state;
            wait_cnt  <= (cur_state == ST_MEM && next_state == ST_MEM) ? wait_cnt + 32'd1 : '0;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_FETCH:  if (if_en) next_state = ST_DECODE;
            ST_DECODE: next_state = (dec.iclass == IC_ILL) ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
                case (dec.iclass)
                    IC_LOAD, IC_STORE:       next_state = ST_MEM;
                    IC_R_ALU, IC_IMM, IC_JAL: next_state = ST_WB;
                    default:                 next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready)
                    next_state = (dec.iclass == IC_LOAD) ? ST_WB : ST_FETCH;
                else if (timeout)
                    next_state = ST_FETCH;
            end
            ST_WB:   next_state = ST_FETCH;
            default: next_state = ST_FETCH;
        endcase
    end

    // Outputs are computed for the state being entered, so the registered value is valid in that state.
    always_comb begin
        if_en_d   = (next_state == ST_FETCH);
        reg_we_d  = (next_state == ST_WB);
        mem_re_d  = (next_state == ST_MEM) && (dec.iclass == IC_LOAD);
        mem_we_d  = (next_state == ST_MEM) && (dec.iclass == IC_STORE);
        alu_op_d  = alu_op;
        alu_src_d = alu_src;
        npc_sel_d = npc_sel;
        reg_dst_d = reg_dst;
        wb_sel_d  = wb_sel;
        cond_d    = cond;
        illegal_d = illegal || (cur_state == ST_DECODE && dec.iclass == IC_ILL);
        bus_err_d = bus_err || timeout;

        if (cur_state == ST_FETCH && if_en)
            cond_d = 1'b0;

        if (next_state == ST_EXEC) begin
            alu_op_d  = dec.alu_op;
            alu_src_d = dec.alu_src;
            case (dec.iclass)
                IC_JMP, IC_JAL: begin npc_sel_d = NPC_JIMM; cond_d = 1'b1; end
                IC_JR:          begin npc_sel_d = NPC_JR;   cond_d = 1'b1; end
                default:        npc_sel_d = NPC_BRANCH;
            endcase
        end

        // Branch outcome is only known once zero is valid, at the end of EXEC.
        if (cur_state == ST_EXEC && dec.iclass == IC_BR)
            cond_d = zero ^ dec.br_ne;

        if (next_state == ST_WB) begin
            case (dec.iclass)
                IC_R_ALU: begin reg_dst_d = DST_RD; wb_sel_d = WB_ALU; end
                IC_LOAD:  begin reg_dst_d = DST_RT; wb_sel_d = WB_MEM; end
                IC_JAL:   begin reg_dst_d = DST_RA; wb_sel_d = WB_PC4; end
                default:  begin reg_dst_d = DST_RT; wb_sel_d = WB_ALU; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_en   <= 1'b0;
            cond    <= 1'b0;
            npc_sel <= NPC_BRANCH;
            reg_we  <= 1'b0;
            reg_dst <= DST_RT;
            alu_src <= 1'b0;
            alu_op  <= ALU_ADD;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            wb_sel  <= WB_ALU;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if_en   <= if_en_d;
            cond    <= cond_d;
            npc_sel <= npc_sel_d;
            reg_we  <= reg_we_d;
            reg_dst <= reg_dst_d;
            alu_src <= alu_src_d;
            alu_op  <= alu_op_d;
            mem_re  <= mem_re_d;
            mem_we  <= mem_we_d;
            wb_sel  <= wb_sel_d;
            illegal <= illegal_d;
            bus_err <= bus_err_d;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic retire;

    // Illegal instructions leave from DECODE and aborts leave MEM without ready, so neither retires.
    assign retire = (next_state == ST_FETCH) &&
                    ((cur_state == ST_EXEC) || (cur_state == ST_WB) ||
                     (cur_state == ST_MEM && mem_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (retire)
                ret_cnt <= ret_cnt + 32'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: directed scenarios then random
// instructions, each compared against a per-instruction behavioural model.
module tb_cpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       if_en, cond, reg_we, alu_src, mem_re, mem_we, illegal, bus_err;
    logic [1:0] npc_sel, reg_dst, wb_sel;
    logic [2:0] alu_op, state;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    bit exp_illegal = 1'b0;
    bit exp_bus_err = 1'b0;

    localparam int TMO = 15;

    cpu_seq_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .if_en     (if_en),
        .cond      (cond),
        .npc_sel   (npc_sel),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .wb_sel    (wb_sel),
        .state     (state),
        .illegal   (illegal),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cycles;
        bit         ill;
        bit         tmo;
        int         we_cycles;
        int         re_cycles;
        int         wr_cycles;
        bit         cond;
        bit         chk_npc;
        logic [1:0] npc;
        bit         chk_alu;
        logic [2:0] alu;
        logic       src;
        logic [1:0] dst;
        logic [1:0] wbs;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected behaviour of one instruction, from the instruction table and cycle-count rules.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input bit z, input int dly);
        exp_t  e;
        string k;
        int    mem_cyc;
        bit    tmo;
        e = '{default: 0};
        tmo = (dly < 0) || (dly >= TMO);
        mem_cyc = tmo ? TMO : dly + 1;
        k = "ill";
        case (op)
            6'h00: begin
                k = "alu";
                case (fn)
                    6'h20: e.alu = 3'd0;
                    6'h22: e.alu = 3'd1;
                    6'h24: e.alu = 3'd2;
                    6'h25: e.alu = 3'd3;
                    6'h2A: e.alu = 3'd4;
                    6'h08: k = "jr";
                    default: k = "ill";
                endcase
            end
            6'h23: begin k = "lw";  e.alu = 3'd0; e.src = 1'b1; end
            6'h2B: begin k = "sw";  e.alu = 3'd0; e.src = 1'b1; end
            6'h04: begin k = "br";  e.alu = 3'd1; e.cond = z;  end
            6'h05: begin k = "br";  e.alu = 3'd1; e.cond = !z; end
            6'h08: begin k = "imm"; e.alu = 3'd0; e.src = 1'b1; end
            6'h0D: begin k = "imm"; e.alu = 3'd3; e.src = 1'b1; end
            6'h02: k = "j";
            6'h03: k = "jal";
            default: k = "ill";
        endcase
        case (k)
            "alu": begin e.cycles = 4; e.we_cycles = 1; e.dst = 2'b01; e.wbs = 2'b00; e.chk_alu = 1; end
            "imm": begin e.cycles = 4; e.we_cycles = 1; e.dst = 2'b00; e.wbs = 2'b00; e.chk_alu = 1; end
            "lw": begin
                e.cycles = tmo ? 3 + TMO : 5 + dly;
                e.re_cycles = mem_cyc; e.we_cycles = tmo ? 0 : 1;
                e.dst = 2'b00; e.wbs = 2'b01; e.tmo = tmo; e.chk_alu = 1;
            end
            "sw": begin e.cycles = 3 + mem_cyc; e.wr_cycles = mem_cyc; e.tmo = tmo; e.chk_alu = 1; end
            "br": begin e.cycles = 3; e.chk_npc = 1; e.npc = 2'b00; e.chk_alu = 1; end
            "j":  begin e.cycles = 3; e.cond = 1; e.chk_npc = 1; e.npc = 2'b01; end
            "jr": begin e.cycles = 3; e.cond = 1; e.chk_npc = 1; e.npc = 2'b10; end
            "jal": begin
                e.cycles = 4; e.cond = 1; e.chk_npc = 1; e.npc = 2'b01;
                e.we_cycles = 1; e.dst = 2'b10; e.wbs = 2'b10;
            end
            default: begin e.cycles = 2; e.ill = 1; end
        endcase
        return e;
    endfunction

    task automatic wait_fetch(input string tag);
        int k = 0;
        while (if_en !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_fetch_seen"}, 32'(if_en), 32'd1);
    endtask

    // Runs one instruction from its if_en cycle to the next if_en cycle and compares with the model.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input bit z, input int dly);
        exp_t       e;
        int         n = 1, mk = 0, we = 0, re = 0, wr = 0;
        logic [2:0] alu_seen = 'x;
        logic       src_seen = 'x;
        logic [1:0] dst_seen = 'x, wbs_seen = 'x;
        e = model(op, fn, z, dly);
        wait_fetch(tag);
        opcode = op;
        funct = fn;
        zero = 1'($urandom);
        mem_ready = 1'($urandom);
        do begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                check({tag, "_decode_state"}, 32'(state), 32'd1);
                check({tag, "_cond_cleared"}, 32'(cond), 32'd0);
            end
            if (n >= 3 && if_en !== 1'b1) begin
                opcode = 6'($urandom);
                funct = 6'($urandom);
            end
            if (state == 3'd2) begin
                alu_seen = alu_op;
                src_seen = alu_src;
            end
            zero = (state == 3'd2) ? z : 1'($urandom);
            if (state == 3'd3) begin
                mem_ready = (dly >= 0) && (mk == dly);
                mk++;
            end else begin
                mem_ready = 1'($urandom);
            end
            if (reg_we === 1'b1) begin
                we++;
                dst_seen = reg_dst;
                wbs_seen = wb_sel;
            end
            if (mem_re === 1'b1) re++;
            if (mem_we === 1'b1) wr++;
        end while (if_en !== 1'b1 && n < 40);

        exp_illegal = exp_illegal | e.ill;
        exp_bus_err = exp_bus_err | e.tmo;
        check({tag, "_cycles"}, 32'(n - 1), 32'(e.cycles));
        check({tag, "_fetch_state"}, 32'(state), 32'd0);
        check({tag, "_reg_we_cycles"}, 32'(we), 32'(e.we_cycles));
        check({tag, "_mem_re_cycles"}, 32'(re), 32'(e.re_cycles));
        check({tag, "_mem_we_cycles"}, 32'(wr), 32'(e.wr_cycles));
        check({tag, "_cond"}, 32'(cond), 32'(e.cond));
        check({tag, "_illegal"}, 32'(illegal), 32'(exp_illegal));
        check({tag, "_bus_err"}, 32'(bus_err), 32'(exp_bus_err));
        if (e.chk_npc) check({tag, "_npc_sel"}, 32'(npc_sel), 32'(e.npc));
        if (e.chk_alu) begin
            check({tag, "_alu_op"}, 32'(alu_seen), 32'(e.alu));
            check({tag, "_alu_src"}, 32'(src_seen), 32'(e.src));
        end
        if (e.we_cycles != 0) begin
            check({tag, "_reg_dst"}, 32'(dst_seen), 32'(e.dst));
            check({tag, "_wb_sel"}, 32'(wbs_seen), 32'(e.wbs));
        end
    endtask

    logic [5:0] enc_op [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B,
                                6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h03, 6'h3F, 6'h00};
    logic [5:0] enc_fn [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h21};

    initial begin
        rst = 1'b1;
        opcode = '0;
        funct = '0;
        zero = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_if_en", 32'(if_en), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_cond", 32'(cond), 32'd0);
        check("rst_mem_req", 32'({mem_re, mem_we}), 32'd0);
        check("rst_selects", 32'({npc_sel, reg_dst, wb_sel, alu_op, alu_src}), 32'd0);
        check("rst_sticky", 32'({illegal, bus_err}), 32'd0);

        rst = 1'b0;
        @(negedge clk);
        check("first_if_en", 32'(if_en), 32'd1);

        run_instr("add", 6'h00, 6'h20, 1'b0, 0);
        run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0);
        run_instr("beq_not_taken", 6'h04, 6'h00, 1'b0, 0);
        run_instr("lw_wait2", 6'h23, 6'h00, 1'b0, 2);
        run_instr("sw_timeout", 6'h2B, 6'h00, 1'b0, -1);
        run_instr("illegal_3f", 6'h3F, 6'h00, 1'b0, 0);
        run_instr("jal", 6'h03, 6'h00, 1'b0, 0);
        run_instr("j", 6'h02, 6'h00, 1'b1, 0);
        run_instr("jr", 6'h00, 6'h08, 1'b0, 0);

        // Reset taken in each state clears state, enables and sticky flags.
        for (int s = 0; s < 5; s++) begin
            int k = 0;
            run_instr("pre_ill", 6'h3F, 6'h00, 1'b0, 0);
            opcode = (s == 4) ? 6'h00 : 6'h23;
            funct = 6'h20;
            mem_ready = 1'b0;
            while (state !== 3'(s) && k < 10) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("reach_state%0d", s), 32'(state), 32'(s));
            rst = 1'b1;
            @(negedge clk);
            check($sformatf("rst_in_%0d_state", s), 32'(state), 32'd0);
            repeat (2) @(negedge clk);
            check($sformatf("rst_in_%0d_if_en", s), 32'(if_en), 32'd0);
            check($sformatf("rst_in_%0d_reg_we", s), 32'(reg_we), 32'd0);
            check($sformatf("rst_in_%0d_mem_re", s), 32'(mem_re), 32'd0);
            check($sformatf("rst_in_%0d_illegal", s), 32'(illegal), 32'd0);
            rst = 1'b0;
            exp_illegal = 1'b0;
            exp_bus_err = 1'b0;
        end

        for (int i = 0; i < 40; i++) begin
            int idx;
            int dly;
            idx = $urandom_range(0, 15);
            dly = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? -1 : 17)
                                              : int'($urandom_range(0, 4));
            run_instr($sformatf("rnd%0d", i), enc_op[idx], enc_fn[idx], 1'($urandom), dly);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
